// File: rtl/button_event_ctrl_pkg.sv
// Shared types and default sizing for the push-button event front end.
package btn_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned PULSE_DEF = 150;
  localparam int unsigned ID_W      = $clog2(WIDTH_DEF);
  localparam int unsigned CNT_W     = $clog2(PULSE_DEF + 1);

  // Output handshake state: nothing offered / event offered and held.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } evt_state_t;

  // Width helper that never returns zero (a 1-value range still needs a bit).
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Valid/ready event port carrying the channel index of a button press.
interface button_evt_if #(
  parameter int unsigned WIDTH = 4
) ();

  localparam int unsigned ID_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_id, output evt_ready);

endinterface

// File: rtl/button_event_ctrl_debounce_chan.sv
// One button channel: saturating sample counter, debounced level, rising-edge pulse.
module debounce_chan #(
  parameter int unsigned PULSE_CNT_MAX = 150,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  input  logic i_tick,
  output logic o_level,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_CNT_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_level_d;

  // Next count: any low sample restarts, high samples on a tick count up and saturate.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_sync) begin
      w_cnt_nxt = '0;
    end else if (i_tick && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Counter, level and delayed level; level is registered from the next count so it tracks r_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_level   <= (w_cnt_nxt == CNT_MAX);
      r_level_d <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/button_event_ctrl.sv
// Push-button front end: synchronize, debounce, detect presses, queue one per
// channel and round-robin them onto a single valid/ready event port.
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned SAMPLE_CNT_MAX = 25000,
  parameter int unsigned PULSE_CNT_MAX  = 150
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_async,
  output logic [WIDTH-1:0] btn_level,
  button_evt_if.master     evt,
  output logic [WIDTH-1:0] evt_overflow,
  input  logic             ovf_clear
);

  localparam int unsigned L_ID_W  = clog2_min1(WIDTH);
  localparam int unsigned L_CNT_W = clog2_min1(PULSE_CNT_MAX + 1);
  localparam int unsigned TMR_W   = clog2_min1(SAMPLE_CNT_MAX);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [L_ID_W-1:0] PTR_INIT = L_ID_W'(WIDTH - 1);

  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_sync2;
  logic [TMR_W-1:0]  r_tmr;
  logic              w_tick;
  logic [WIDTH-1:0]  w_level;
  logic [WIDTH-1:0]  w_press;
  logic [WIDTH-1:0]  r_pend;
  logic [WIDTH-1:0]  r_ovf;
  logic [WIDTH-1:0]  w_grant;
  logic              w_grant_en;
  logic              w_found;
  logic [L_ID_W-1:0] w_winner;
  logic [L_ID_W-1:0] r_ptr;
  logic [L_ID_W-1:0] r_id;
  logic              r_valid;
  evt_state_t        r_state;

  // Two-stage synchronizer for the raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_async;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample timer shared by all channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_tick) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  assign w_tick = (r_tmr == TMR_LAST);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_chan #(
      .PULSE_CNT_MAX (PULSE_CNT_MAX),
      .CNT_W         (L_CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_sync  (r_sync2[g]),
      .i_tick  (w_tick),
      .o_level (w_level[g]),
      .o_press (w_press[g])
    );
  end

  // Round-robin pick: first pending channel after the last winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      int unsigned idx;
      idx = (32'(r_ptr) + 1 + k) % WIDTH;
      if (!w_found && r_pend[idx]) begin
        w_found  = 1'b1;
        w_winner = L_ID_W'(idx);
      end
    end
  end

  // A grant happens whenever the port is free (IDLE) or being emptied (HOLD + ready).
  always_comb begin
    w_grant    = '0;
    w_grant_en = w_found && ((r_state == IDLE) || evt.evt_ready);
    if (w_grant_en) begin
      w_grant[w_winner] = 1'b1;
    end
  end

  // Pending presses and sticky overflow; a press on a channel granted this cycle re-queues cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_press;
      r_ovf  <= (r_ovf & ~{WIDTH{ovf_clear}}) | (w_press & r_pend & ~w_grant);
    end
  end

  // Output FSM with registered valid/id; reloads straight from HOLD for back-to-back events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= PTR_INIT;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            r_id    <= w_winner;
            r_ptr   <= w_winner;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (evt.evt_ready) begin
            if (w_grant_en) begin
              r_id  <= w_winner;
              r_ptr <= w_winner;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign btn_level     = w_level;
  assign evt_overflow  = r_ovf;
  assign evt.evt_valid = r_valid;
  assign evt.evt_id    = r_id;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with fast debounce parameters.
module tb_button_event_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] btn_async;
  logic [W-1:0] btn_level;
  logic [W-1:0] evt_overflow;
  logic         ovf_clear;

  int checks   = 0;
  int failures = 0;

  // Events seen by the collector: id and cycle index.
  int ev_n;
  int ev_id  [16];
  int ev_cyc [16];
  int lvl_first;

  button_evt_if #(.WIDTH(W)) u_if ();

  button_event_ctrl #(
    .WIDTH          (W),
    .SAMPLE_CNT_MAX (4),
    .PULSE_CNT_MAX  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_async    (btn_async),
    .btn_level    (btn_level),
    .evt          (u_if),
    .evt_overflow (evt_overflow),
    .ovf_clear    (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles, logging every accepted event and the first cycle a watched level goes high.
  task automatic collect(input int n, input int watch);
    for (int i = 1; i <= n; i++) begin
      step();
      if (watch >= 0 && lvl_first < 0 && btn_level[watch] === 1'b1) lvl_first = i;
      if (u_if.evt_valid === 1'b1 && u_if.evt_ready === 1'b1 && ev_n < 16) begin
        ev_id[ev_n]  = int'(u_if.evt_id);
        ev_cyc[ev_n] = i;
        ev_n++;
      end
    end
  endtask

  task automatic clear_log();
    ev_n      = 0;
    lvl_first = -1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic bad;
    btn_async = 4'hF;
    u_if.evt_ready = 1'b0;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (btn_level !== 4'hF) begin
      failures++;
      $display("FAIL reset_pre_level got=%h exp=%h", btn_level, 4'hF);
    end
    checks++;
    if (u_if.evt_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_valid got=%b exp=1", u_if.evt_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 4'h0 || evt_overflow !== 4'h0) begin
      failures++;
      $display("FAIL reset_async_level_ovf got=%h/%h exp=0/0", btn_level, evt_overflow);
    end
    checks++;
    if (u_if.evt_valid !== 1'b0 || u_if.evt_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_async_evt got=%b/%0d exp=0/0", u_if.evt_valid, u_if.evt_id);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (btn_level !== 4'h0 || u_if.evt_valid !== 1'b0 || evt_overflow !== 4'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_held got=nonzero exp=all zero while rst_n low");
    end
    btn_async = 4'h0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_clean_press();
    u_if.evt_ready = 1'b1;
    clear_log();
    btn_async[1] = 1'b1;
    collect(40, 1);
    checks++;
    if (lvl_first < 0 || lvl_first > 17) begin
      failures++;
      $display("FAIL press_level_latency got=%0d exp=1..17", lvl_first);
    end
    checks++;
    if (ev_n !== 1) begin
      failures++;
      $display("FAIL press_event_count got=%0d exp=1", ev_n);
    end
    checks++;
    if (ev_n > 0 && ev_id[0] !== 1) begin
      failures++;
      $display("FAIL press_event_id got=%0d exp=1", ev_id[0]);
    end
    clear_log();
    btn_async[1] = 1'b0;
    collect(10, -1);
    checks++;
    if (ev_n !== 0 || btn_level !== 4'h0) begin
      failures++;
      $display("FAIL release_no_event got=%0d/%h exp=0/0", ev_n, btn_level);
    end
  endtask

  task automatic test_bounce();
    logic seen_lvl;
    logic seen_vld;
    seen_lvl = 1'b0;
    seen_vld = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) btn_async[0] = ~btn_async[0];
      step();
      if (btn_level[0] !== 1'b0) seen_lvl = 1'b1;
      if (u_if.evt_valid !== 1'b0) seen_vld = 1'b1;
    end
    btn_async[0] = 1'b0;
    checks++;
    if (seen_lvl) begin
      failures++;
      $display("FAIL bounce_level got=1 exp=never 1");
    end
    checks++;
    if (seen_vld) begin
      failures++;
      $display("FAIL bounce_valid got=1 exp=never 1");
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_fairness();
    // Fresh pointer (WIDTH-1) so the first pair starts its search at channel 0.
    pulse_reset();
    u_if.evt_ready = 1'b1;
    clear_log();
    btn_async = 4'b0101;
    collect(25, -1);
    btn_async = 4'b0000;
    collect(8, -1);
    checks++;
    if (ev_n !== 2) begin
      failures++;
      $display("FAIL fair_a_count got=%0d exp=2", ev_n);
    end else begin
      checks++;
      if (ev_id[0] !== 0 || ev_id[1] !== 2) begin
        failures++;
        $display("FAIL fair_a_order got=%0d,%0d exp=0,2", ev_id[0], ev_id[1]);
      end
      checks++;
      if (ev_cyc[1] - ev_cyc[0] !== 1) begin
        failures++;
        $display("FAIL fair_a_b2b got=%0d exp=1", ev_cyc[1] - ev_cyc[0]);
      end
    end
    clear_log();
    btn_async = 4'b1001;
    collect(25, -1);
    btn_async = 4'b0000;
    collect(8, -1);
    checks++;
    if (ev_n !== 2) begin
      failures++;
      $display("FAIL fair_b_count got=%0d exp=2", ev_n);
    end else begin
      checks++;
      if (ev_id[0] !== 3 || ev_id[1] !== 0) begin
        failures++;
        $display("FAIL fair_b_order got=%0d,%0d exp=3,0", ev_id[0], ev_id[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    u_if.evt_ready = 1'b0;
    // First press occupies the port, second fills the pending slot, third overflows.
    btn_async[1] = 1'b1; for (int i = 0; i < 20; i++) step();
    btn_async[1] = 1'b0; for (int i = 0; i < 8; i++) step();
    btn_async[1] = 1'b1; for (int i = 0; i < 20; i++) step();
    checks++;
    if (evt_overflow !== 4'b0000) begin
      failures++;
      $display("FAIL bp_no_ovf_yet got=%b exp=0000", evt_overflow);
    end
    btn_async[1] = 1'b0; for (int i = 0; i < 8; i++) step();
    btn_async[1] = 1'b1; for (int i = 0; i < 20; i++) step();
    btn_async[1] = 1'b0; for (int i = 0; i < 8; i++) step();
    checks++;
    if (u_if.evt_valid !== 1'b1 || u_if.evt_id !== 2'd1) begin
      failures++;
      $display("FAIL bp_hold got=%b/%0d exp=1/1", u_if.evt_valid, u_if.evt_id);
    end
    checks++;
    if (evt_overflow !== 4'b0010) begin
      failures++;
      $display("FAIL bp_overflow got=%b exp=0010", evt_overflow);
    end
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    checks++;
    if (evt_overflow !== 4'b0000) begin
      failures++;
      $display("FAIL bp_ovf_clear got=%b exp=0000", evt_overflow);
    end
    u_if.evt_ready = 1'b1;
    step();
    checks++;
    if (u_if.evt_valid !== 1'b1 || u_if.evt_id !== 2'd1) begin
      failures++;
      $display("FAIL bp_reload got=%b/%0d exp=1/1", u_if.evt_valid, u_if.evt_id);
    end
    step();
    checks++;
    if (u_if.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%b exp=0", u_if.evt_valid);
    end
    u_if.evt_ready = 1'b0;
    step();
    checks++;
    if (u_if.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle got=%b exp=0", u_if.evt_valid);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic seen;
    u_if.evt_ready = 1'b1;
    btn_async[2] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (btn_level[2] !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre_level got=%b exp=0", btn_level[2]);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    btn_async[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (btn_level !== 4'h0 || u_if.evt_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_reset_no_event got=activity exp=none");
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    btn_async      = '0;
    ovf_clear      = 1'b0;
    u_if.evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_clean_press();
    test_bounce();
    test_fairness();
    test_backpressure();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
